// File: rtl/lap_stopwatch_core_pkg.sv
// Shared definitions for the lap stopwatch core: FSM state encoding,
// BCD digit geometry and the field layout of the 16-bit display bus.
package lap_stopwatch_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSE  = 2'b10,
        ST_RECALL = 2'b11
    } state_t;

    localparam int DIGIT_W = 4;
    localparam int BCD_W   = 4 * DIGIT_W;
    localparam int SEC_MAX = 59;

    // Display bus layout {min10, min1, sec10, sec1}
    localparam int SEC1_LSB  = 0;
    localparam int SEC10_LSB = 4;
    localparam int MIN1_LSB  = 8;
    localparam int MIN10_LSB = 12;

    // True when an mm:ss BCD word reads 00:00
    function automatic logic bcd_is_zero(input logic [BCD_W-1:0] t);
        return (t == {BCD_W{1'b0}});
    endfunction

endpackage

// File: rtl/lap_stopwatch_core_counter.sv
// Four-digit mm:ss BCD counter. Counts on i_en, clears synchronously on
// i_clr, and saturates at MAX_MIN:59 (an enable at the ceiling is ignored).
module bcd_mmss_counter
    import lap_stopwatch_core_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [BCD_W-1:0] o_time_bcd,
    output logic             o_at_max
);

    localparam logic [DIGIT_W-1:0] MIN10_MAX = DIGIT_W'(MAX_MIN / 10);
    localparam logic [DIGIT_W-1:0] MIN1_MAX  = DIGIT_W'(MAX_MIN % 10);
    localparam logic [DIGIT_W-1:0] SEC10_MAX = DIGIT_W'(SEC_MAX / 10);
    localparam logic [DIGIT_W-1:0] SEC1_MAX  = DIGIT_W'(SEC_MAX % 10);
    localparam logic [DIGIT_W-1:0] DIGIT_9   = DIGIT_W'(9);
    localparam logic [DIGIT_W-1:0] DIGIT_0   = {DIGIT_W{1'b0}};
    localparam logic [DIGIT_W-1:0] DIGIT_1   = DIGIT_W'(1);

    logic [DIGIT_W-1:0] r_sec1;
    logic [DIGIT_W-1:0] r_sec10;
    logic [DIGIT_W-1:0] r_min1;
    logic [DIGIT_W-1:0] r_min10;
    logic               w_at_max;

    assign w_at_max = (r_min10 == MIN10_MAX) && (r_min1 == MIN1_MAX) &&
                      (r_sec10 == SEC10_MAX) && (r_sec1 == SEC1_MAX);

    // Digit registers with seconds-to-minutes carry chain; held at the ceiling
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sec1  <= DIGIT_0;
            r_sec10 <= DIGIT_0;
            r_min1  <= DIGIT_0;
            r_min10 <= DIGIT_0;
        end else if (i_clr) begin
            r_sec1  <= DIGIT_0;
            r_sec10 <= DIGIT_0;
            r_min1  <= DIGIT_0;
            r_min10 <= DIGIT_0;
        end else if (i_en && !w_at_max) begin
            if (r_sec1 == DIGIT_9) begin
                r_sec1 <= DIGIT_0;
                if (r_sec10 == SEC10_MAX) begin
                    r_sec10 <= DIGIT_0;
                    if (r_min1 == DIGIT_9) begin
                        r_min1  <= DIGIT_0;
                        r_min10 <= r_min10 + DIGIT_1;
                    end else begin
                        r_min1  <= r_min1 + DIGIT_1;
                    end
                end else begin
                    r_sec10 <= r_sec10 + DIGIT_1;
                end
            end else begin
                r_sec1 <= r_sec1 + DIGIT_1;
            end
        end else begin
            r_sec1  <= r_sec1;
            r_sec10 <= r_sec10;
            r_min1  <= r_min1;
            r_min10 <= r_min10;
        end
    end

    assign o_time_bcd = {r_min10, r_min1, r_sec10, r_sec1};
    assign o_at_max   = w_at_max;

endmodule

// File: rtl/lap_stopwatch_core.sv
// Stopwatch core: IDLE/RUN/PAUSE/RECALL FSM, lap buffer with write count
// and sticky overflow, recall index and display source selection.
module lap_stopwatch_core
    import lap_stopwatch_core_pkg::*;
#(
    parameter  int LAP_DEPTH = 4,
    parameter  int MAX_MIN   = 59,
    localparam int IDX_W     = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
    localparam int CNT_W     = $clog2(LAP_DEPTH + 1)
) (
    input  logic             _1Hzclk,
    input  logic             init_rst,
    input  logic             stsp_sign,
    input  logic             lap_sign,
    input  logic             rcl_sign,
    output logic [15:0]      disp_bcd,
    output logic             running,
    output logic             recall_mode,
    output logic [IDX_W-1:0] lap_idx,
    output logic [CNT_W-1:0] lap_count,
    output logic             lap_full,
    output logic             lap_ovf,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LAP_DEPTH);
    localparam logic [CNT_W-1:0] CNT_0   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_1   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_0   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_1   = IDX_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_cnt_en;
    logic               w_cnt_clr;
    logic               w_lap_wr;
    logic               w_ovf_set;
    logic               w_laps_clr;
    logic               w_idx_inc;
    logic [BCD_W-1:0]   w_time_bcd;
    logic               w_at_max;
    logic               w_has_laps;
    logic               w_full;
    logic               w_idx_last;
    logic [BCD_W-1:0]   r_lap_buf [LAP_DEPTH];
    logic [CNT_W-1:0]   r_lap_count;
    logic [IDX_W-1:0]   r_lap_idx;
    logic               r_lap_ovf;

    bcd_mmss_counter #(
        .MAX_MIN    (MAX_MIN)
    ) u_counter (
        .i_clk      (_1Hzclk),
        .i_rst_n    (init_rst),
        .i_clr      (w_cnt_clr),
        .i_en       (w_cnt_en),
        .o_time_bcd (w_time_bcd),
        .o_at_max   (w_at_max)
    );

    assign w_has_laps = (r_lap_count != CNT_0);
    assign w_full     = (r_lap_count == DEPTH_C);
    assign w_idx_last = (CNT_W'(r_lap_idx) == (r_lap_count - CNT_1));

    // State register
    always_ff @(posedge _1Hzclk or negedge init_rst) begin
        if (!init_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes; stsp outranks lap, lap outranks rcl
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_en    = 1'b0;
        w_cnt_clr   = 1'b0;
        w_lap_wr    = 1'b0;
        w_ovf_set   = 1'b0;
        w_laps_clr  = 1'b0;
        w_idx_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (stsp_sign) begin
                    w_state_nxt = ST_RUN;
                end else if (lap_sign) begin
                    w_state_nxt = ST_IDLE;
                end else if (rcl_sign && w_has_laps) begin
                    w_state_nxt = ST_RECALL;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stsp_sign) begin
                    w_state_nxt = ST_PAUSE;
                end else begin
                    // Lap captures the pre-increment time, even on the saturating edge
                    if (lap_sign) begin
                        if (w_full) begin
                            w_ovf_set = 1'b1;
                        end else begin
                            w_lap_wr = 1'b1;
                        end
                    end else begin
                        w_lap_wr = 1'b0;
                    end
                    if (w_at_max) begin
                        w_state_nxt = ST_PAUSE;
                    end else begin
                        w_cnt_en    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_PAUSE: begin
                if (stsp_sign) begin
                    w_state_nxt = ST_RUN;
                end else if (lap_sign) begin
                    w_cnt_clr   = 1'b1;
                    w_laps_clr  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (rcl_sign && w_has_laps) begin
                    w_state_nxt = ST_RECALL;
                end else begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_RECALL: begin
                if (stsp_sign) begin
                    w_state_nxt = bcd_is_zero(w_time_bcd) ? ST_IDLE : ST_PAUSE;
                end else if (lap_sign) begin
                    w_state_nxt = ST_RECALL;
                end else if (rcl_sign && w_has_laps) begin
                    w_idx_inc   = 1'b1;
                    w_state_nxt = ST_RECALL;
                end else begin
                    w_state_nxt = ST_RECALL;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Lap count and sticky overflow; both cleared by the PAUSE clear
    always_ff @(posedge _1Hzclk or negedge init_rst) begin
        if (!init_rst) begin
            r_lap_count <= CNT_0;
            r_lap_ovf   <= 1'b0;
        end else if (w_laps_clr) begin
            r_lap_count <= CNT_0;
            r_lap_ovf   <= 1'b0;
        end else if (w_lap_wr) begin
            r_lap_count <= r_lap_count + CNT_1;
            r_lap_ovf   <= r_lap_ovf;
        end else if (w_ovf_set) begin
            r_lap_count <= r_lap_count;
            r_lap_ovf   <= 1'b1;
        end else begin
            r_lap_count <= r_lap_count;
            r_lap_ovf   <= r_lap_ovf;
        end
    end

    // Lap storage; entries survive a clear since lap_count marks validity
    always_ff @(posedge _1Hzclk or negedge init_rst) begin
        if (!init_rst) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                r_lap_buf[i] <= {BCD_W{1'b0}};
            end
        end else if (w_lap_wr) begin
            r_lap_buf[r_lap_count[IDX_W-1:0]] <= w_time_bcd;
        end else begin
            r_lap_buf <= r_lap_buf;
        end
    end

    // Recall index: zero outside RECALL, wraps after the last stored lap
    always_ff @(posedge _1Hzclk or negedge init_rst) begin
        if (!init_rst) begin
            r_lap_idx <= IDX_0;
        end else if (w_state_nxt != ST_RECALL) begin
            r_lap_idx <= IDX_0;
        end else if (w_idx_inc) begin
            r_lap_idx <= w_idx_last ? IDX_0 : (r_lap_idx + IDX_1);
        end else begin
            r_lap_idx <= r_lap_idx;
        end
    end

    assign disp_bcd    = (r_state == ST_RECALL) ? r_lap_buf[r_lap_idx] : w_time_bcd;
    assign running     = (r_state == ST_RUN);
    assign recall_mode = (r_state == ST_RECALL);
    assign lap_idx     = r_lap_idx;
    assign lap_count   = r_lap_count;
    assign lap_full    = w_full;
    assign lap_ovf     = r_lap_ovf;
    assign at_max      = w_at_max;

endmodule

// File: tb/tb_lap_stopwatch_core.sv
// Scoreboard bench for lap_stopwatch_core (LAP_DEPTH=4, MAX_MIN=1).
// The driver applies one pulse vector per clock and queues the hand-computed
// outputs expected after that edge; monitors pop and compare independently.
module tb_lap_stopwatch_core;

    localparam int LAP_DEPTH = 4;
    localparam int MAX_MIN   = 1;
    localparam int NA        = -1;

    logic        clk;
    logic        init_rst;
    logic        stsp_sign;
    logic        lap_sign;
    logic        rcl_sign;
    logic [15:0] disp_bcd;
    logic        running;
    logic        recall_mode;
    logic [1:0]  lap_idx;
    logic [2:0]  lap_count;
    logic        lap_full;
    logic        lap_ovf;
    logic        at_max;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string name;
        int    disp;
        int    run;
        int    rcl;
        int    idx;
        int    cnt;
        int    full;
        int    ovf;
        int    amax;
    } exp_t;

    exp_t exp_q[$];

    lap_stopwatch_core #(
        .LAP_DEPTH   (LAP_DEPTH),
        .MAX_MIN     (MAX_MIN)
    ) u_dut (
        ._1Hzclk     (clk),
        .init_rst    (init_rst),
        .stsp_sign   (stsp_sign),
        .lap_sign    (lap_sign),
        .rcl_sign    (rcl_sign),
        .disp_bcd    (disp_bcd),
        .running     (running),
        .recall_mode (recall_mode),
        .lap_idx     (lap_idx),
        .lap_count   (lap_count),
        .lap_full    (lap_full),
        .lap_ovf     (lap_ovf),
        .at_max      (at_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input string field, input int want, input logic [31:0] got);
        if (want >= 0) begin
            n_checks++;
            if (got !== 32'(want)) begin
                n_errors++;
                $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, got, want);
            end
        end
    endtask

    task automatic check_one();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e.name, "disp_bcd",    e.disp, 32'(disp_bcd));
            cmp(e.name, "running",     e.run,  32'(running));
            cmp(e.name, "recall_mode", e.rcl,  32'(recall_mode));
            cmp(e.name, "lap_idx",     e.idx,  32'(lap_idx));
            cmp(e.name, "lap_count",   e.cnt,  32'(lap_count));
            cmp(e.name, "lap_full",    e.full, 32'(lap_full));
            cmp(e.name, "lap_ovf",     e.ovf,  32'(lap_ovf));
            cmp(e.name, "at_max",      e.amax, 32'(at_max));
        end
    endtask

    // Clocked monitor: outputs after each active edge
    always @(posedge clk) begin
        #1;
        check_one();
    end

    // Reset monitor: outputs must clear without waiting for a clock
    always @(negedge init_rst) begin
        #1;
        check_one();
    end

    task automatic push_exp(input string name, input int disp, input int run, input int rcl,
                            input int idx, input int cnt, input int full, input int ovf, input int amax);
        exp_t e;
        e.name = name; e.disp = disp; e.run = run; e.rcl = rcl; e.idx = idx;
        e.cnt = cnt; e.full = full; e.ovf = ovf; e.amax = amax;
        exp_q.push_back(e);
    endtask

    task automatic tick(input logic s, input logic l, input logic r);
        @(negedge clk);
        stsp_sign = s;
        lap_sign  = l;
        rcl_sign  = r;
    endtask

    task automatic tick_exp(input logic s, input logic l, input logic r, input string name,
                            input int disp, input int run, input int rcl, input int idx,
                            input int cnt, input int full, input int ovf, input int amax);
        tick(s, l, r);
        push_exp(name, disp, run, rcl, idx, cnt, full, ovf, amax);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic apply_reset(input string name);
        @(negedge clk);
        stsp_sign = 1'b0;
        lap_sign  = 1'b0;
        rcl_sign  = 1'b0;
        #1;
        push_exp(name, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
        init_rst = 1'b0;
        // a start pulse while reset is held must have no effect
        tick_exp(1'b1, 1'b0, 1'b0, {name, "_hold"}, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        stsp_sign = 1'b0;
        init_rst  = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init_rst  = 1'b1;
        stsp_sign = 1'b0;
        lap_sign  = 1'b0;
        rcl_sign  = 1'b0;

        apply_reset("por");

        // 65 seconds of running, then pause holds the time
        tick_exp(1, 0, 0, "t1_start",  16'h0000, 1, 0, 0, 0, 0, 0, 0);
        idle(64);
        tick_exp(0, 0, 0, "t1_0105",   16'h0105, 1, 0, 0, 0, 0, 0, 0);
        tick_exp(1, 0, 0, "t1_pause",  16'h0105, 0, 0, 0, 0, 0, 0, 0);
        tick_exp(0, 0, 0, "t1_hold1",  16'h0105, 0, 0, NA, NA, NA, NA, 0);
        tick_exp(0, 0, 0, "t1_hold2",  16'h0105, 0, 0, NA, NA, NA, NA, 0);
        tick_exp(0, 1, 0, "t1_clear",  16'h0000, 0, 0, 0, 0, 0, 0, 0);

        // laps at 00:03, 00:07, 00:10 then browse
        tick_exp(1, 0, 0, "t2_start",  16'h0000, 1, 0, 0, 0, 0, 0, 0);
        idle(3);
        tick_exp(0, 1, 0, "t2_lap1",   16'h0004, 1, 0, 0, 1, 0, 0, 0);
        idle(3);
        tick_exp(0, 1, 0, "t2_lap2",   16'h0008, 1, 0, 0, 2, 0, 0, 0);
        idle(2);
        tick_exp(0, 1, 0, "t2_lap3",   16'h0011, 1, 0, 0, 3, 0, 0, 0);
        tick_exp(1, 0, 0, "t2_pause",  16'h0011, 0, 0, 0, 3, 0, 0, 0);
        tick_exp(0, 0, 1, "t2_rcl0",   16'h0003, 0, 1, 0, 3, 0, 0, 0);
        tick_exp(0, 0, 1, "t2_rcl1",   16'h0007, 0, 1, 1, 3, 0, 0, 0);
        tick_exp(0, 0, 1, "t2_rcl2",   16'h0010, 0, 1, 2, 3, 0, 0, 0);
        tick_exp(0, 0, 1, "t2_wrap",   16'h0003, 0, 1, 0, 3, 0, 0, 0);
        tick_exp(0, 0, 0, "t2_frozen", 16'h0003, 0, 1, 0, 3, 0, 0, 0);
        tick_exp(0, 1, 0, "t2_lapign", 16'h0003, 0, 1, 0, 3, 0, 0, 0);
        tick_exp(0, 1, 1, "t2_lappri", 16'h0003, 0, 1, 0, 3, 0, 0, 0);
        tick_exp(1, 0, 0, "t2_exit",   16'h0011, 0, 0, 0, 3, 0, 0, 0);

        // stsp and lap together in RUN: only the pause happens
        tick_exp(1, 0, 0, "t3_resume", 16'h0011, 1, 0, 0, 3, 0, 0, 0);
        tick_exp(0, 0, 0, "t3_inc",    16'h0012, 1, 0, 0, 3, 0, 0, 0);
        tick_exp(1, 1, 0, "t3_stsplap",16'h0012, 0, 0, 0, 3, 0, 0, 0);

        // clear from PAUSE with 3 laps, then recall is ignored
        tick_exp(0, 1, 0, "t4_clear",  16'h0000, 0, 0, 0, 0, 0, 0, 0);
        tick_exp(0, 0, 1, "t4_rclign", 16'h0000, 0, 0, 0, 0, 0, 0, 0);

        // five laps into a four-entry buffer
        tick_exp(1, 0, 0, "t5_start",  16'h0000, 1, 0, 0, 0, 0, 0, 0);
        tick_exp(0, 1, 0, "t5_lap1",   16'h0001, 1, 0, 0, 1, 0, 0, 0);
        tick_exp(0, 1, 0, "t5_lap2",   16'h0002, 1, 0, 0, 2, 0, 0, 0);
        tick_exp(0, 1, 0, "t5_lap3",   16'h0003, 1, 0, 0, 3, 0, 0, 0);
        tick_exp(0, 1, 0, "t5_lap4",   16'h0004, 1, 0, 0, 4, 1, 0, 0);
        tick_exp(0, 1, 0, "t5_lap5",   16'h0005, 1, 0, 0, 4, 1, 1, 0);
        tick_exp(1, 0, 0, "t5_pause",  16'h0005, 0, 0, 0, 4, 1, 1, 0);
        tick_exp(0, 0, 1, "t5_rcl0",   16'h0000, 0, 1, 0, 4, 1, 1, 0);
        tick_exp(0, 0, 1, "t5_rcl1",   16'h0001, 0, 1, 1, 4, 1, 1, 0);
        tick_exp(0, 0, 1, "t5_rcl2",   16'h0002, 0, 1, 2, 4, 1, 1, 0);
        tick_exp(0, 0, 1, "t5_rcl3",   16'h0003, 0, 1, 3, 4, 1, 1, 0);
        tick_exp(0, 0, 1, "t5_wrap",   16'h0000, 0, 1, 0, 4, 1, 1, 0);
        tick_exp(1, 0, 0, "t5_exit",   16'h0005, 0, 0, 0, 4, 1, 1, 0);
        tick_exp(0, 1, 0, "t5_clear",  16'h0000, 0, 0, 0, 0, 0, 0, 0);

        // saturation at 01:59
        tick_exp(1, 0, 0, "t6_start",  16'h0000, 1, 0, 0, 0, 0, 0, 0);
        idle(117);
        tick_exp(0, 0, 0, "t6_0158",   16'h0158, 1, 0, 0, 0, 0, 0, 0);
        tick_exp(0, 0, 0, "t6_0159",   16'h0159, 1, 0, 0, 0, 0, 0, 1);
        tick_exp(0, 1, 0, "t6_satlap", 16'h0159, 0, 0, 0, 1, 0, 0, 1);
        tick_exp(0, 0, 0, "t6_hold",   16'h0159, 0, 0, 0, 1, 0, 0, 1);
        tick_exp(1, 0, 0, "t6_rerun",  16'h0159, 1, 0, 0, 1, 0, 0, 1);
        tick_exp(0, 0, 0, "t6_repause",16'h0159, 0, 0, 0, 1, 0, 0, 1);
        tick_exp(0, 0, 1, "t6_recall", 16'h0159, 0, 1, 0, 1, 0, 0, 1);
        tick_exp(0, 0, 1, "t6_rclone", 16'h0159, 0, 1, 0, 1, 0, 0, 1);

        // asynchronous reset while in RECALL
        apply_reset("rst_recall");
        tick_exp(1, 0, 0, "t7_run",    16'h0000, 1, 0, 0, 0, 0, 0, 0);
        tick_exp(0, 0, 0, "t7_inc",    16'h0001, 1, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        stsp_sign = 1'b0;
        lap_sign  = 1'b0;
        rcl_sign  = 1'b0;
        repeat (3) @(negedge clk);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
